// File: rtl/decision_sequencer.sv
// Sequencer for the decision-tree classifier: issues start pulses, collects
// y/valid responses into saturating per-class counters, logs invalid codes
// and timeouts, and exposes all counters through a muxed read port.
module decision_sequencer #(
  parameter int CNT_W   = 16,
  parameter int RUN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic [RUN_W-1:0] num_runs_i,
  output logic             start_o,
  input  logic [7:0]       y_i,
  input  logic             y_valid_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [2:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  // One extra bit keeps TIMEOUT-1 representable for any TIMEOUT >= 2.
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             state;
  logic [RUN_W-1:0]   num_runs;
  logic [RUN_W-1:0]   runs_done;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   cnt [0:5];

  logic               accept;
  logic               timer_expired;
  logic               wait_evt;
  logic               last_run;
  logic               inc_en;
  logic [2:0]         inc_idx;

  // Event decode for the WAIT state and counter increment selection.
  always_comb begin
    accept        = (state == IDLE) && run_i;
    timer_expired = (timer == TMR_LAST);
    wait_evt      = y_valid_i || timer_expired;
    // Wider compare so runs_done+1 cannot wrap at the top of the range.
    last_run      = (({1'b0, runs_done} + (RUN_W+1)'(1)) == {1'b0, num_runs});
    inc_en        = (state == WAIT) && wait_evt;
    inc_idx       = 3'd5;
    if (y_valid_i) begin
      // A valid response always wins over a coincident timeout.
      case (y_i)
        8'd1:    inc_idx = 3'd0;
        8'd2:    inc_idx = 3'd1;
        8'd3:    inc_idx = 3'd2;
        8'd4:    inc_idx = 3'd3;
        default: inc_idx = 3'd4;
      endcase
    end
  end

  // Main sequencing FSM with registered start/busy/done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      start_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      num_runs  <= '0;
      runs_done <= '0;
      timer     <= '0;
    end else begin
      start_o <= 1'b0;
      done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (run_i) begin
            runs_done <= '0;
            if (num_runs_i != '0) begin
              num_runs <= num_runs_i;
              state    <= START;
              start_o  <= 1'b1;
              busy_o   <= 1'b1;
            end else begin
              // Zero-length command completes without touching the classifier.
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end
          end
        end
        START: begin
          timer  <= '0;
          state  <= WAIT;
          busy_o <= 1'b1;
        end
        WAIT: begin
          if (wait_evt) begin
            runs_done <= runs_done + 1'b1;
            if (last_run) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state   <= START;
              start_o <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Six saturating result counters, cleared on reset or on an accepted command.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset || accept) begin
          cnt[gi] <= '0;
        end else if (inc_en && (inc_idx == 3'(gi)) && (cnt[gi] != {CNT_W{1'b1}})) begin
          cnt[gi] <= cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // Counter read mux; unused selects read as zero.
  always_comb begin
    cnt_o = '0;
    case (cnt_sel_i)
      3'd0:    cnt_o = cnt[0];
      3'd1:    cnt_o = cnt[1];
      3'd2:    cnt_o = cnt[2];
      3'd3:    cnt_o = cnt[3];
      3'd4:    cnt_o = cnt[4];
      3'd5:    cnt_o = cnt[5];
      default: cnt_o = '0;
    endcase
  end

endmodule

// File: tb/tb_decision_sequencer.sv
// Directed bench for decision_sequencer: a delay-programmable responder model
// answers start pulses; expected counter sets are queued per command and
// compared when done_o appears.
module tb_decision_sequencer;

  localparam int CNT_W   = 4;
  localparam int RUN_W   = 8;
  localparam int TIMEOUT = 8;

  logic             clk;
  logic             reset;
  logic             run_i;
  logic [RUN_W-1:0] num_runs_i;
  logic             start_o;
  logic [7:0]       y_i;
  logic             y_valid_i;
  logic             busy_o;
  logic             done_o;
  logic [2:0]       cnt_sel_i;
  logic [CNT_W-1:0] cnt_o;

  decision_sequencer #(.CNT_W(CNT_W), .RUN_W(RUN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .num_runs_i(num_runs_i),
    .start_o(start_o), .y_i(y_i), .y_valid_i(y_valid_i), .busy_o(busy_o),
    .done_o(done_o), .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int run_cyc = 0;
  int done_cyc = 0;
  int sb_q[$];

  // Responder model state (written only by the responder process).
  logic       resp_valid = 1'b0;
  logic [7:0] resp_y = 8'd0;
  int         resp_count = 0;
  // Responder controls (written only by the main process).
  logic       resp_on = 1'b0;
  int         resp_delay = 3;
  int         resp_base = 0;
  logic [7:0] resp_codes [0:4];
  logic       stray_valid = 1'b0;
  logic [7:0] stray_y = 8'd0;

  assign y_valid_i = resp_valid | stray_valid;
  assign y_i       = stray_valid ? stray_y : resp_y;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_o) n_start <= n_start + 1;
    if (done_o)  n_done  <= n_done + 1;
  end

  // Responder: valid arrives resp_delay cycles after each observed start pulse.
  initial begin
    int cd;
    logic pending;
    cd = 0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      resp_valid = 1'b0;
      if (pending) begin
        cd--;
        if (cd == 0) begin
          resp_valid = 1'b1;
          resp_y     = resp_codes[(resp_count - resp_base) % 5];
          pending    = 1'b0;
          resp_count++;
        end
      end
      if (start_o && resp_on) begin
        pending = 1'b1;
        cd      = resp_delay;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic read_cnt(input int k, output logic [31:0] v);
    @(negedge clk);
    cnt_sel_i = 3'(k);
    #1 v = 32'(cnt_o);
  endtask

  task automatic run_cmd(input int n);
    @(negedge clk);
    run_i      = 1'b1;
    num_runs_i = RUN_W'(n);
    run_cyc    = cyc;
    @(negedge clk);
    run_i      = 1'b0;
  endtask

  task automatic push_exp(input int y1, input int y2, input int y3, input int y4,
                          input int inv, input int tmo);
    sb_q.push_back(y1); sb_q.push_back(y2); sb_q.push_back(y3);
    sb_q.push_back(y4); sb_q.push_back(inv); sb_q.push_back(tmo);
  endtask

  // Wait (bounded) for done_o, then pop the queued expectation and compare.
  task automatic wait_done(input string tag, input int budget);
    logic got;
    logic [31:0] v;
    int e;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    done_cyc = cyc;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    for (int k = 0; k < 6; k++) begin
      e = sb_q.pop_front();
      read_cnt(k, v);
      check($sformatf("%s_cnt%0d", tag, k), v, 32'(e));
    end
  endtask

  initial begin
    logic [31:0] v;
    int s0, d0;
    for (int k = 0; k < 5; k++) resp_codes[k] = 8'd1;
    reset = 1'b1; run_i = 1'b0; num_runs_i = '0; cnt_sel_i = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_done",  32'(done_o),  32'd0);
    for (int k = 0; k < 8; k++) begin
      read_cnt(k, v);
      check($sformatf("rst_cnt%0d", k), v, 32'd0);
    end

    // 1: y=1 three cycles after each start, four evaluations
    resp_on = 1'b1; resp_delay = 3;
    s0 = n_start; d0 = n_done;
    push_exp(4, 0, 0, 0, 0, 0);
    run_cmd(4);
    wait_done("t1", 200);
    repeat (5) @(negedge clk);
    check("t1_starts", 32'(n_start - s0), 32'd4);
    check("t1_dones",  32'(n_done - d0),  32'd1);

    // 2: rotating codes 1,2,3,4,7
    resp_codes[0] = 8'd1; resp_codes[1] = 8'd2; resp_codes[2] = 8'd3;
    resp_codes[3] = 8'd4; resp_codes[4] = 8'd7;
    resp_base = resp_count;
    push_exp(1, 1, 1, 1, 1, 0);
    run_cmd(5);
    wait_done("t2", 300);

    // 3: no response, two timeouts, exact completion latency
    resp_on = 1'b0;
    push_exp(0, 0, 0, 0, 0, 2);
    run_cmd(2);
    wait_done("t3", 300);
    check("t3_latency", 32'(done_cyc - run_cyc), 32'(2 * (TIMEOUT + 1) + 1));

    // 4: valid on the timeout cycle wins; stray valid in IDLE is ignored
    for (int k = 0; k < 5; k++) resp_codes[k] = 8'd3;
    resp_base = resp_count;
    resp_on = 1'b1; resp_delay = TIMEOUT;
    push_exp(0, 0, 1, 0, 0, 0);
    run_cmd(1);
    wait_done("t4", 200);
    resp_on = 1'b0;
    @(negedge clk);
    stray_y = 8'd1; stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    read_cnt(0, v); check("t4_stray_y1", v, 32'd0);
    read_cnt(2, v); check("t4_stray_y3", v, 32'd1);

    // 5: reset during WAIT of run 2 of 3, then a zero-length command
    s0 = n_start; d0 = n_done;
    run_cmd(3);
    for (int i = 0; i < 200 && n_start < s0 + 2; i++) @(negedge clk);
    check("t5_second_start", 32'(n_start - s0), 32'd2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_start", 32'(start_o), 32'd0);
    check("t5_busy",  32'(busy_o),  32'd0);
    check("t5_done",  32'(done_o),  32'd0);
    for (int k = 0; k < 6; k++) begin
      read_cnt(k, v);
      check($sformatf("t5_cnt%0d", k), v, 32'd0);
    end
    repeat (20) @(negedge clk);
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    s0 = n_start;
    push_exp(0, 0, 0, 0, 0, 0);
    run_cmd(0);
    wait_done("t5z", 20);
    check("t5z_latency", 32'(done_cyc - run_cyc), 32'd1);
    check("t5z_starts",  32'(n_start - s0), 32'd0);

    // 6: saturation at 15, second run_i while busy ignored
    for (int k = 0; k < 5; k++) resp_codes[k] = 8'd2;
    resp_base = resp_count;
    resp_on = 1'b1; resp_delay = 2;
    s0 = n_start; d0 = n_done;
    push_exp(0, 15, 0, 0, 0, 0);
    run_cmd(20);
    repeat (10) @(negedge clk);
    run_i = 1'b1; num_runs_i = RUN_W'(3);
    @(negedge clk);
    run_i = 1'b0;
    wait_done("t6", 400);
    repeat (5) @(negedge clk);
    check("t6_starts", 32'(n_start - s0), 32'd20);
    check("t6_dones",  32'(n_done - d0),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
